// File: rtl/reverse_lut_16.sv
// Reverse lookup table: 16 writable entries scanned one per cycle for the
// lowest index whose contents equal a latched search key.
module reverse_lut_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [WIDTH-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [3:0]       idx
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int          ENTRIES  = 16;
    localparam logic [3:0]  LAST_PTR = 4'd15;

    function automatic logic entry_match(
        input logic [WIDTH-1:0] entry,
        input logic [WIDTH-1:0] target
    );
        return (entry == target);
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       ptr_q,   ptr_d;
    logic [WIDTH-1:0] key_q,   key_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             hit_q,   hit_d;
    logic [3:0]       idx_q,   idx_d;
    logic [WIDTH-1:0] lut_q [ENTRIES];
    logic [WIDTH-1:0] lut_d [ENTRIES];
    logic             cur_match_s;

    // Table write port; compares read lut_q, so a same-edge write is not seen.
    always_comb begin
        lut_d = lut_q;
        if (wr_en) begin
            lut_d[wr_idx] = wr_data;
        end else begin
            lut_d[wr_idx] = lut_q[wr_idx];
        end
    end

    // Scan controller next-state and result logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        key_d       = key_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hit_d       = hit_q;
        idx_d       = idx_q;
        cur_match_s = entry_match(lut_q[ptr_q], key_q);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key;
                    ptr_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (cur_match_s) begin
                    done_d  = 1'b1;
                    hit_d   = 1'b1;
                    idx_d   = ptr_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (ptr_q == LAST_PTR) begin
                    // Last entry missed: finish without wrapping the pointer.
                    done_d  = 1'b1;
                    hit_d   = 1'b0;
                    idx_d   = 4'd0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d   = ptr_q + 4'd1;
                    state_d = ST_SCAN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, result and table registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 4'd0;
            key_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= 4'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            for (int i = 0; i < ENTRIES; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hit  = hit_q;
    assign idx  = idx_q;

endmodule

// File: tb/tb_reverse_lut_16.sv
// Scoreboard bench for reverse_lut_16: searches push expected results,
// a negedge monitor pops and compares each done pulse.
module tb_reverse_lut_16;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [15:0] wr_data;
    logic        start;
    logic [15:0] key;
    logic        busy;
    logic        done;
    logic        hit;
    logic [3:0]  idx;

    typedef struct {
        logic       hit;
        logic [3:0] idx;
        int         cyc;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    reverse_lut_16 #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .start   (start),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .hit     (hit),
        .idx     (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_hit", int'(hit), int'(e.hit));
                chk("done_idx", int'(idx), int'(e.idx));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_write(input logic [3:0] i, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_idx  = i;
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Issue one search; optional extra start, mid-scan write or reset at busy count N.
    task automatic do_search(input logic [15:0] k, input logic eh, input logic [3:0] ei,
                             input int lat, input int extra_at, input int wr_at,
                             input logic [3:0] wi, input logic [15:0] wd, input int rst_at);
        int  cnt;
        bit  fin;
        exp_t e;
        if (rst_at < 0) begin
            e.hit = eh;
            e.idx = ei;
            e.cyc = cyc + 1 + lat;
            exp_q.push_back(e);
        end
        start = 1'b1;
        key   = k;
        if (wr_at == 0) begin
            wr_en   = 1'b1;
            wr_idx  = wi;
            wr_data = wd;
        end
        @(posedge clk); #1;
        key = 16'hDEAD;
        cnt = 0;
        fin = 1'b0;
        while (!fin && cnt < 40) begin
            start = 1'b0;
            wr_en = 1'b0;
            if (busy) begin
                cnt++;
                if (cnt == extra_at) begin
                    start = 1'b1;
                    key   = 16'h1000;
                end
                if (cnt == wr_at) begin
                    wr_en   = 1'b1;
                    wr_idx  = wi;
                    wr_data = wd;
                end
                if (cnt == rst_at) begin
                    reset_n = 1'b0;
                    #1;
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_done", int'(done), 0);
                    chk("rst_hit", int'(hit), 0);
                    chk("rst_idx", int'(idx), 0);
                    fin = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end else begin
                fin = 1'b1;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (rst_at < 0) begin
            chk("busy_cycles", cnt, lat);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = 4'd0;
        wr_data = 16'h0000;
        start   = 1'b0;
        key     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_idx", int'(idx), 0);

        // Cleared table: key 0 hits entry 0 on the first compare.
        do_search(16'h0000, 1'b1, 4'd0, 1, -1, -1, 4'd0, 16'h0000, -1);

        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 16'h1000 + 16'(i));
        end
        do_search(16'h1007, 1'b1, 4'd7, 8, -1, -1, 4'd0, 16'h0000, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_hit", int'(hit), 1);
        chk("hold_idx", int'(idx), 7);

        // Full miss with an ignored start while busy.
        do_search(16'hBEEF, 1'b0, 4'd0, 16, 3, -1, 4'd0, 16'h0000, -1);
        // Start coinciding with the done edge is ignored.
        do_search(16'h1007, 1'b1, 4'd7, 8, 8, -1, 4'd0, 16'h0000, -1);

        do_write(4'd3, 16'h00AA);
        do_write(4'd9, 16'h00AA);
        do_search(16'h00AA, 1'b1, 4'd3, 4, -1, -1, 4'd0, 16'h0000, -1);
        do_write(4'd3, 16'h0000);
        do_search(16'h00AA, 1'b1, 4'd9, 10, -1, -1, 4'd0, 16'h0000, -1);

        // Mid-scan writes to entry 12: ahead of, behind, and at the pointer.
        do_search(16'h5555, 1'b1, 4'd12, 13, -1, 6, 4'd12, 16'h5555, -1);
        do_write(4'd12, 16'h100C);
        do_search(16'h5555, 1'b0, 4'd0, 16, -1, 14, 4'd12, 16'h5555, -1);
        do_write(4'd12, 16'h100C);
        do_search(16'h5555, 1'b0, 4'd0, 16, -1, 13, 4'd12, 16'h5555, -1);
        do_write(4'd12, 16'h100C);

        // Write and start on the same edge.
        do_search(16'h7777, 1'b1, 4'd0, 1, -1, 0, 4'd0, 16'h7777, -1);

        // Reset while ptr=6 aborts the search without a done pulse.
        do_search(16'h1234, 1'b0, 4'd0, 16, -1, -1, 4'd0, 16'h0000, 7);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        do_search(16'h1007, 1'b0, 4'd0, 16, -1, -1, 4'd0, 16'h0000, -1);
        do_search(16'h7777, 1'b0, 4'd0, 16, -1, -1, 4'd0, 16'h0000, -1);
        do_search(16'h0000, 1'b1, 4'd0, 1, -1, -1, 4'd0, 16'h0000, -1);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reverse_lut_16.md
REVERSE_LUT_16 -- requirements
Module: reverse_lut_16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the bit width of each table entry and of the search key.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port wr_en  input  1  table write strobe.
REQ-005 SHALL have port wr_idx  input  4  entry index to write.
REQ-006 SHALL have port wr_data  input  WIDTH  value to store at wr_idx.
REQ-007 SHALL have port start  input  1  search request.
REQ-008 SHALL have port key  input  WIDTH  value to search for; sampled with start.
REQ-009 SHALL have port busy  output  1  high while a search is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a search completes.
REQ-011 SHALL have port hit  output  1  result flag: key was found.
REQ-012 SHALL have port idx  output  4  result: lowest matching entry index, or 0 on a miss.

Function
REQ-013 SHALL hold a 16-entry x WIDTH table written by wr_en/wr_idx/wr_data at the clock edge; a write is visible to compares from the next cycle.
REQ-014 SHALL implement the states IDLE and SCAN, with a 4-bit scan pointer and a WIDTH-bit latched key.
REQ-015 In IDLE, start=1 at an edge SHALL latch key, set ptr=0 and busy=1, and move to SCAN.
REQ-016 In SCAN, each edge SHALL compare table[ptr] against the latched key, with exactly one entry compared per cycle.
REQ-017 On a match at ptr=k, the same edge SHALL set done=1, hit=1, idx=k and busy=0, and return to IDLE; a match at entry k therefore gives done k+1 edges after the start edge.
REQ-018 On a mismatch with ptr<15, the edge SHALL increment ptr and stay in SCAN.
REQ-019 On a mismatch with ptr=15, the edge SHALL set done=1, hit=0, idx=0 and busy=0, and return to IDLE (16 edges after start); ptr SHALL NOT wrap into further compares.
REQ-020 done SHALL be high for exactly one cycle per search.
REQ-021 hit and idx SHALL hold their values until the next search completes.
REQ-022 start while busy=1 SHALL be ignored; changes on key during SCAN SHALL have no effect.
REQ-023 start on the same edge that done is produced SHALL be ignored, because the state is still SCAN at that edge; a new search is accepted from the following cycle.
REQ-024 A write during SCAN to an entry not yet compared SHALL affect the result.
REQ-025 A write to the entry being compared at that same edge SHALL NOT affect that compare; the old value is used.
REQ-026 A write to an already-compared entry SHALL NOT affect the result.
REQ-027 Duplicate values in the table SHALL resolve to the lowest index.
REQ-028 Simultaneous wr_en and start SHALL both take effect, and the write SHALL be visible to the search.

Reset
REQ-029 reset_n=0 SHALL immediately, independent of clk, force state=IDLE, ptr=0, latched key=0, all table entries=0, busy=0, done=0, hit=0, idx=0.
REQ-030 Reset asserted mid-search SHALL abort the search with no done pulse.
REQ-031 Operation SHALL resume on the first rising edge after reset_n returns to 1.

Verification
REQ-032 Bench SHALL cover: after reset, start with key=0 -> done one edge after start, hit=1, idx=0 (all entries 0 after reset).
REQ-033 Bench SHALL cover: load entry i with 16'h1000+i, start with key=16'h1007 -> done 8 edges after start, hit=1, idx=7, busy high for 8 cycles.
REQ-034 Bench SHALL cover: same table, key=16'hBEEF -> done 16 edges after start, hit=0, idx=0; a second start pulsed during busy produces no extra done.
REQ-035 Bench SHALL cover: entries 3 and 9 both 16'h00AA, key=16'h00AA -> idx=3; then rewrite entry 3 to 0 and repeat -> idx=9.
REQ-036 Bench SHALL cover: during a search for 16'h5555, write entry 12 <= 16'h5555 while ptr=5 -> hit=1, idx=12; the same write issued while ptr=13 -> hit=0.
REQ-037 Bench SHALL cover: reset_n pulsed low while ptr=6 -> busy=0 and done=0 immediately, with no done pulse afterwards, and all entries read back as misses for nonzero keys.
